// File: rtl/seq_alu_arbiter_if.sv
// seq_alu_arbiter_if
// Bundles the requester handshake, the response channel and the shared-ALU
// control/result lines of seq_alu_arbiter.
//   slave  : the arbiter view (takes requests, drives the ALU, returns results)
//   master : the environment view (requesters, response consumer, ALU)
// Signals:
//   req_valid/req_ready            per-requester request handshake
//   req_a/req_b/req_op             packed per-requester operands and opcode
//   resp_valid/resp_ready          result handshake
//   resp_id/resp_data              result tag and captured ALU value
//   busy                           arbiter not idle
//   alu_en/alu_A/alu_B/alu_opcode  ALU issue lines
//   alu_result                     ALU output
interface seq_alu_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int RES_W  = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*OP_W-1:0]   req_op;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [ID_W-1:0]         resp_id;
  logic [RES_W-1:0]        resp_data;
  logic                    busy;
  logic                    alu_en;
  logic [DATA_W-1:0]       alu_A;
  logic [DATA_W-1:0]       alu_B;
  logic [OP_W-1:0]         alu_opcode;
  logic [RES_W-1:0]        alu_result;

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready, alu_result,
    output req_ready, resp_valid, resp_id, resp_data, busy,
           alu_en, alu_A, alu_B, alu_opcode
  );

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_id, resp_data, busy,
           alu_en, alu_A, alu_B, alu_opcode
  );
endinterface

// File: rtl/seq_alu_arbiter.sv
// seq_alu_arbiter
// Round-robin arbiter/sequencer sharing one fixed-latency sequential ALU
// between N_REQ requesters. One operation is in flight at a time:
// IDLE (grant) -> ISSUE (alu_en pulse) -> WAIT (ALU latency) -> RESP.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  seq_alu_arbiter_if.slave (request, response and ALU lines)
module seq_alu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int RES_W   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  seq_alu_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  // Counter only has to hold ALU_LAT-1.
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic [ID_W-1:0]   r_resp_id;
  logic [RES_W-1:0]  r_resp_data;
  logic              r_alu_en;
  logic              r_resp_valid;
  logic              r_busy;
  logic [N_REQ-1:0]  w_req_ready;
  logic              w_grant_found;
  logic [ID_W-1:0]   w_grant_idx;
  logic [ID_W-1:0]   w_scan_idx;
  logic              w_hit;

  // Round-robin search: first valid requester at or after r_ptr, wrapping.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan_idx    = '0;
    w_hit         = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan_idx    = ID_W'((int'(r_ptr) + k) % N_REQ);
      w_hit         = bus.req_valid[w_scan_idx] & ~w_grant_found;
      w_grant_idx   = w_hit ? w_scan_idx : w_grant_idx;
      w_grant_found = w_grant_found | w_hit;
    end
  end

  // Next-state and the combinational acceptance pulse.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_found) begin
          w_next_state = ST_ISSUE;
          // Gated by rst so no acceptance is signalled while held in reset.
          w_req_ready[w_grant_idx] = rst;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the winner's operands and index at the grant edge; held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_resp_id <= '0;
    end else if ((r_state == ST_IDLE) && w_grant_found) begin
      r_alu_a   <= bus.req_a[w_grant_idx*DATA_W +: DATA_W];
      r_alu_b   <= bus.req_b[w_grant_idx*DATA_W +: DATA_W];
      r_alu_op  <= bus.req_op[w_grant_idx*OP_W +: OP_W];
      r_resp_id <= w_grant_idx;
    end
  end

  // Latency countdown and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        ST_ISSUE: r_cnt <= CNT_INIT;
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_data <= bus.alu_result;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Round-robin pointer advances past the requester just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if ((r_state == ST_RESP) && bus.resp_ready) begin
      r_ptr <= (r_resp_id == LAST_ID) ? '0 : r_resp_id + ID_W'(1);
    end
  end

  // Status outputs registered from the next state so they track the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_en     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_alu_en     <= (w_next_state == ST_ISSUE);
      r_resp_valid <= (w_next_state == ST_RESP);
      r_busy       <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.busy       = r_busy;
  assign bus.alu_en     = r_alu_en;
  assign bus.alu_A      = r_alu_a;
  assign bus.alu_B      = r_alu_b;
  assign bus.alu_opcode = r_alu_op;
endmodule

// File: tb/tb_seq_alu_arbiter.sv
// tb_seq_alu_arbiter
// Two arbiter instances (ALU latency 1 and 3) driven one at a time, each with a
// behavioural ALU. A transaction-timing reference model predicts grants,
// alu_en, response timing and values from the requester rules.
module tb_seq_alu_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_alu_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .RES_W(RW)) if1 ();
  seq_alu_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .RES_W(RW)) if3 ();

  seq_alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .RES_W(RW), .ALU_LAT(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .RES_W(RW), .ALU_LAT(3))
    dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  // Requester-side stimulus
  logic [N-1:0]    pend = '0;
  logic [DW-1:0]   op_a [N];
  logic [DW-1:0]   op_b [N];
  logic [OW-1:0]   op_c [N];
  logic            resp_rdy = 1'b1;
  int              sel = 0;
  int              lat = 1;
  bit              refill = 1'b0;
  bit              rnd = 1'b0;
  logic [N*DW-1:0] pa, pb;
  logic [N*OW-1:0] pc;

  always_comb begin
    pa = '0; pb = '0; pc = '0;
    for (int i = 0; i < N; i++) begin
      pa[i*DW +: DW] = op_a[i];
      pb[i*DW +: DW] = op_b[i];
      pc[i*OW +: OW] = op_c[i];
    end
  end

  assign if1.req_valid  = (sel == 0) ? pend : '0;
  assign if3.req_valid  = (sel == 1) ? pend : '0;
  assign if1.req_a = pa; assign if1.req_b = pb; assign if1.req_op = pc;
  assign if3.req_a = pa; assign if3.req_b = pb; assign if3.req_op = pc;
  assign if1.resp_ready = resp_rdy;
  assign if3.resp_ready = resp_rdy;

  // Behavioural ALU: op0 add, op1 sub, op2 mul, others xor.
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return {8'd0, a} + {8'd0, b};
      4'd1:    return {8'd0, a} - {8'd0, b};
      4'd2:    return {8'd0, a} * {8'd0, b};
      default: return {8'd0, a ^ b};
    endcase
  endfunction

  logic        p1_vld;
  logic [15:0] p1_val;
  logic [2:0]  p3_vld;
  logic [15:0] p3_val [3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_vld <= 1'b0;
      p3_vld <= 3'b000;
    end else begin
      p1_vld    <= if1.alu_en;
      p1_val    <= alu_f(if1.alu_A, if1.alu_B, if1.alu_opcode);
      p3_vld    <= {p3_vld[1:0], if3.alu_en};
      p3_val[0] <= alu_f(if3.alu_A, if3.alu_B, if3.alu_opcode);
      p3_val[1] <= p3_val[0];
      p3_val[2] <= p3_val[1];
    end
  end
  // Outside its valid cycle the ALU shows a poison value.
  assign if1.alu_result = p1_vld    ? p1_val    : 16'hEEEE;
  assign if3.alu_result = p3_vld[2] ? p3_val[2] : 16'hEEEE;

  // Observed outputs of the active instance
  logic [N-1:0] o_ready;
  logic         o_rv, o_busy, o_en;
  logic [1:0]   o_id;
  logic [15:0]  o_data;
  logic [7:0]   o_A, o_B;
  logic [3:0]   o_op;
  always_comb begin
    if (sel == 1) begin
      o_ready = if3.req_ready; o_rv = if3.resp_valid; o_busy = if3.busy;
      o_en = if3.alu_en; o_id = if3.resp_id; o_data = if3.resp_data;
      o_A = if3.alu_A; o_B = if3.alu_B; o_op = if3.alu_opcode;
    end else begin
      o_ready = if1.req_ready; o_rv = if1.resp_valid; o_busy = if1.busy;
      o_en = if1.alu_en; o_id = if1.resp_id; o_data = if1.resp_data;
      o_A = if1.alu_A; o_B = if1.alu_B; o_op = if1.alu_opcode;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one operation at a time, timed from its grant cycle.
  bit          m_busy = 1'b0;
  int          m_t0 = 0, m_id = 0, m_ptr = 0, cyc = 0;
  logic [15:0] m_exp;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_op;
  logic [N-1:0] prev_ready = '0;

  task automatic model_check();
    logic [N-1:0] er;
    bit een, ev;
    int g;
    if (!rst) begin
      chk("rst_ready", o_ready, 0);  chk("rst_busy", o_busy, 0);
      chk("rst_alu_en", o_en, 0);    chk("rst_resp_valid", o_rv, 0);
      chk("rst_alu_A", o_A, 0);      chk("rst_alu_B", o_B, 0);
      chk("rst_opcode", o_op, 0);    chk("rst_resp_id", o_id, 0);
      chk("rst_resp_data", o_data, 0);
      m_busy = 1'b0;
      m_ptr  = 0;
      return;
    end
    er = '0;
    g  = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) er[g] = 1'b1;
    end
    chk("grant", o_ready, er);
    een = m_busy && (cyc == m_t0 + 1);
    chk("alu_en", o_en, een);
    if (een) begin
      chk("alu_A", o_A, m_a); chk("alu_B", o_B, m_b); chk("alu_opcode", o_op, m_op);
    end
    ev = m_busy && (cyc >= m_t0 + 2 + lat);
    chk("resp_valid", o_rv, ev);
    if (ev) begin
      chk("resp_id", o_id, m_id);
      chk("resp_data", o_data, m_exp);
    end
    chk("busy", o_busy, m_busy);
    if (g >= 0) begin
      m_busy = 1'b1; m_t0 = cyc; m_id = g;
      m_a = op_a[g]; m_b = op_b[g]; m_op = op_c[g];
      m_exp = alu_f(op_a[g], op_b[g], op_c[g]);
    end else if (ev && resp_rdy) begin
      m_busy = 1'b0;
      m_ptr  = (m_id + 1) % N;
    end
  endtask

  task automatic new_op(input int i);
    op_a[i] = 8'($urandom);
    op_b[i] = 8'($urandom);
    op_c[i] = 4'($urandom_range(3));
  endtask

  // Advance one clock; requesters react to the acceptance seen last cycle.
  task automatic start_cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (prev_ready[i]) begin
        if (refill) new_op(i);
        else pend[i] = 1'b0;
      end
    end
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          new_op(i);
        end else if (pend[i] && $urandom_range(15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      resp_rdy = ($urandom_range(2) != 0);
    end
  endtask

  task automatic end_cycle();
    #1;
    model_check();
    prev_ready = o_ready;
  endtask

  task automatic cycle();
    start_cycle();
    end_cycle();
  endtask

  task automatic wait_grant(input string tag);
    for (int t = 0; t < 20 && prev_ready == '0; t++) cycle();
    chk(tag, (prev_ready != '0), 1);
  endtask

  task automatic drain();
    start_cycle();
    pend = '0;
    resp_rdy = 1'b1;
    end_cycle();
    for (int t = 0; t < 20 && m_busy; t++) cycle();
    cycle();
    chk("drain_idle", o_busy, 0);
  endtask

  int gq[$];
  int cq[$];

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = '0;
    end

    // Reset held with all requests valid
    start_cycle(); pend = 4'b1111; end_cycle();
    cycle();
    // Release with no requests: idle for 10 cycles
    start_cycle(); rst = 1'b1; pend = '0; end_cycle();
    for (int t = 0; t < 9; t++) cycle();
    chk("idle_alu_en", o_en, 0);
    chk("idle_busy", o_busy, 0);

    // Fairness: all requesters continuously valid
    start_cycle();
    for (int i = 0; i < N; i++) new_op(i);
    pend = 4'b1111; refill = 1'b1;
    end_cycle();
    for (int t = 0; t < 40 && gq.size() < 6; t++) begin
      if (t > 0) cycle();
      for (int i = 0; i < N; i++) begin
        if (prev_ready[i]) begin gq.push_back(i); cq.push_back(cyc); end
      end
    end
    chk("fair_count", gq.size(), 6);
    for (int k = 0; k < gq.size(); k++) begin
      chk("fair_order", gq[k], k % N);
      if (k > 0) chk("fair_gap", cq[k] - cq[k-1], 4);
    end
    refill = 1'b0;
    drain();

    // Single request from requester 2: 5 + 3
    start_cycle();
    op_a[2] = 8'h05; op_b[2] = 8'h03; op_c[2] = 4'h0; pend[2] = 1'b1;
    end_cycle();
    wait_grant("sr_grant");
    chk("sr_ready", prev_ready, 4'b0100);
    cycle();
    chk("sr_alu_en", o_en, 1); chk("sr_A", o_A, 8'h05); chk("sr_B", o_B, 8'h03);
    cycle();
    cycle();
    chk("sr_resp_valid", o_rv, 1); chk("sr_resp_id", o_id, 2);
    chk("sr_resp_data", o_data, 16'h0008);
    drain();

    // Back-pressure with a competing requester waiting
    start_cycle(); resp_rdy = 1'b0; new_op(0); pend[0] = 1'b1; end_cycle();
    wait_grant("bp_grant");
    chk("bp_ready", prev_ready, 4'b0001);
    start_cycle(); new_op(3); pend[3] = 1'b1; end_cycle();
    for (int t = 0; t < 10 && !o_rv; t++) cycle();
    chk("bp_rise", o_rv, 1);
    for (int t = 0; t < 5; t++) begin
      cycle();
      chk("bp_valid", o_rv, 1); chk("bp_data", o_data, m_exp);
      chk("bp_id", o_id, 0); chk("bp_ready0", o_ready, 0);
    end
    start_cycle(); resp_rdy = 1'b1; end_cycle();
    cycle();
    chk("bp_idle", o_busy, 0);
    chk("bp_next_grant", prev_ready, 4'b1000);
    drain();

    // Reset while waiting on the ALU
    start_cycle(); new_op(2); pend[2] = 1'b1; end_cycle();
    wait_grant("mr_grant");
    cycle();
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("mr_busy", o_busy, 0); chk("mr_alu_en", o_en, 0);
    chk("mr_resp_valid", o_rv, 0); chk("mr_data", o_data, 0);
    chk("mr_id", o_id, 0); chk("mr_A", o_A, 0);
    for (int t = 0; t < 3; t++) cycle();
    start_cycle();
    new_op(1); new_op(3); pend[1] = 1'b1; pend[3] = 1'b1; rst = 1'b1;
    end_cycle();
    chk("mr_first_grant", prev_ready, 4'b0010);
    drain();

    // Randomised traffic, latency 1
    rnd = 1'b1;
    for (int t = 0; t < 300; t++) cycle();
    rnd = 1'b0;
    drain();

    // Latency 3 instance: 0x10 * 0x04
    start_cycle();
    sel = 1; lat = 3; m_ptr = 0; m_busy = 1'b0;
    op_a[1] = 8'h10; op_b[1] = 8'h04; op_c[1] = 4'h2; pend[1] = 1'b1;
    end_cycle();
    chk("l3_ready", prev_ready, 4'b0010);
    cycle();
    chk("l3_alu_en", o_en, 1);
    cycle(); cycle(); cycle();
    chk("l3_not_yet", o_rv, 0);
    cycle();
    chk("l3_resp_valid", o_rv, 1); chk("l3_resp_id", o_id, 1);
    chk("l3_resp_data", o_data, 16'h0040);
    drain();

    // Randomised traffic, latency 3
    rnd = 1'b1;
    for (int t = 0; t < 200; t++) cycle();
    rnd = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
